// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    localparam int OVERSAMPLE = 16;

    // Trigger thresholds selected by FCR[7:6]
    localparam logic [4:0] TRIG_LVL_0 = 5'd1;
    localparam logic [4:0] TRIG_LVL_1 = 5'd4;
    localparam logic [4:0] TRIG_LVL_2 = 5'd8;
    localparam logic [4:0] TRIG_LVL_3 = 5'd14;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BRK_WAIT
    } uart_rx_state_e;

    typedef struct packed {
        logic       bi;
        logic       fe;
        logic       pe;
        logic [7:0] data;
    } uart_rx_entry_t;

    function automatic logic [4:0] trig_threshold(input logic [1:0] lvl);
        case (lvl)
            2'd0:    return TRIG_LVL_0;
            2'd1:    return TRIG_LVL_1;
            2'd2:    return TRIG_LVL_2;
            default: return TRIG_LVL_3;
        endcase
    endfunction

    // Four character times in 16x ticks: 4 * 16 * (start + data + parity + stop).
    // 1.5 stop bits rounds up to 2.
    function automatic logic [9:0] timeout_ticks(input logic [1:0] wl,
                                                 input logic       pen,
                                                 input logic       stb);
        logic [3:0] frame_bits;
        frame_bits = 4'd6 + {2'b00, wl} + {3'b000, pen} + (stb ? 4'd2 : 4'd1);
        return {frame_bits, 6'b000000};
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead RX FIFO of character entries with flush, variable capacity
// (full depth or a single holding register) and a count of error entries.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           fifo_en_i,
    input  logic           flush_i,
    input  logic           push_i,
    input  uart_rx_entry_t push_entry_i,
    input  logic           pop_i,
    output uart_rx_entry_t head_o,
    output logic           empty_o,
    output logic [4:0]     count_o,
    output logic           pop_ok_o,
    output logic           overflow_o,
    output logic           err_any_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    uart_rx_entry_t mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] err_cnt_q, err_cnt_d;
    logic [CW-1:0] capacity;
    logic          full;
    logic          push_ok;
    logic          head_err;
    logic          push_err;

    // Pointer/count bookkeeping; a pop frees its slot before a same-cycle push is judged
    always_comb begin
        capacity   = fifo_en_i ? CW'(DEPTH) : CW'(1);
        full       = (count_q >= capacity);
        empty_o    = (count_q == '0);
        pop_ok_o   = pop_i && !empty_o && !flush_i;
        push_ok    = push_i && !flush_i && (!full || pop_ok_o);
        overflow_o = push_i && !flush_i && full && !pop_ok_o;
        head_o     = empty_o ? '0 : mem_q[rd_ptr_q];
        head_err   = head_o.bi | head_o.fe | head_o.pe;
        push_err   = push_entry_i.bi | push_entry_i.fe | push_entry_i.pe;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        err_cnt_d  = err_cnt_q;
        if (flush_i) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            err_cnt_d = '0;
        end else begin
            wr_ptr_d  = wr_ptr_q + AW'(push_ok);
            rd_ptr_d  = rd_ptr_q + AW'(pop_ok_o);
            count_d   = count_q + CW'(push_ok) - CW'(pop_ok_o);
            err_cnt_d = err_cnt_q + CW'(push_ok && push_err) - CW'(pop_ok_o && head_err);
        end
        count_o   = 5'(count_q);
        err_any_o = (err_cnt_q != '0);
    end

    // Control state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            err_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Entry storage, written only on an accepted push
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_entry_i;
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// UART receive datapath: rx synchronizer, 16x oversampled deframer,
// RX FIFO, LSR status, trigger level and character timeout.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_tick_i,
    input  logic       rx_i,
    input  logic [1:0] word_len_i,
    input  logic       stop_bits_i,
    input  logic       parity_en_i,
    input  logic       even_parity_i,
    input  logic       stick_parity_i,
    input  logic       fifo_en_i,
    input  logic       rx_fifo_reset_i,
    input  logic [1:0] trig_level_i,
    input  logic       pop_i,
    input  logic       lsr_clear_i,
    output logic [7:0] rdata_o,
    output logic       data_ready_o,
    output logic       overrun_o,
    output logic       parity_err_o,
    output logic       framing_err_o,
    output logic       break_o,
    output logic       fifo_err_o,
    output logic       trig_reached_o,
    output logic       timeout_o,
    output logic [4:0] rx_count_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    uart_rx_state_e         state_q, state_d;
    logic [3:0]             tick_cnt_q, tick_cnt_d;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic [7:0]             data_q, data_d;
    logic                   par_bit_q, par_bit_d;
    logic                   fifo_en_q, fifo_en_d;
    logic                   overrun_q, overrun_d;
    logic [9:0]             tmo_cnt_q, tmo_cnt_d;

    logic                   rx_s;
    logic                   last_bit;
    logic                   exp_par;
    logic                   push;
    uart_rx_entry_t         push_entry;
    logic                   flush;
    uart_rx_entry_t         head;
    logic                   fifo_empty;
    logic                   pop_ok;
    logic                   overflow;

    // Metastability synchronizer on the asynchronous serial input
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], rx_i};
        rx_s   = sync_q[SYNC_STAGES-1];
    end

    // Deframer next-state: everything moves only on a 16x tick
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_idx_d  = bit_idx_q;
        data_d     = data_q;
        par_bit_d  = par_bit_q;
        push       = 1'b0;
        push_entry = '0;
        last_bit   = (bit_idx_q == (3'd4 + {1'b0, word_len_i}));
        if (stick_parity_i)     exp_par = ~even_parity_i;
        else if (even_parity_i) exp_par = ^data_q;
        else                    exp_par = ~^data_q;
        if (baud_tick_i) begin
            tick_cnt_d = tick_cnt_q + 4'd1;
            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_d    = START;
                        tick_cnt_d = '0;
                        bit_idx_d  = '0;
                        data_d     = '0;
                        par_bit_d  = 1'b0;
                    end
                end
                START: begin
                    if (tick_cnt_q == 4'd7) begin
                        tick_cnt_d = '0;
                        state_d    = rx_s ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (tick_cnt_q == 4'd15) begin
                        data_d[bit_idx_q] = rx_s;
                        if (last_bit) begin
                            bit_idx_d = '0;
                            state_d   = parity_en_i ? PARITY : STOP;
                        end else begin
                            bit_idx_d = bit_idx_q + 3'd1;
                        end
                    end
                end
                PARITY: begin
                    if (tick_cnt_q == 4'd15) begin
                        par_bit_d = rx_s;
                        state_d   = STOP;
                    end
                end
                STOP: begin
                    if (tick_cnt_q == 4'd15) begin
                        push            = 1'b1;
                        push_entry.data = data_q;
                        push_entry.pe   = parity_en_i && (par_bit_q != exp_par);
                        push_entry.fe   = !rx_s;
                        push_entry.bi   = (data_q == 8'h00) && !par_bit_q && !rx_s;
                        state_d         = push_entry.bi ? BRK_WAIT : IDLE;
                    end
                end
                BRK_WAIT: begin
                    if (rx_s) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Flush detection, sticky overrun and character-timeout counter
    always_comb begin
        fifo_en_d = fifo_en_i;
        flush     = rx_fifo_reset_i || (fifo_en_i != fifo_en_q);
        if (overflow)         overrun_d = 1'b1;
        else if (lsr_clear_i) overrun_d = 1'b0;
        else                  overrun_d = overrun_q;
        if (push || pop_ok || flush || fifo_empty || !fifo_en_i)
            tmo_cnt_d = '0;
        else if (baud_tick_i && (tmo_cnt_q != 10'h3FF))
            tmo_cnt_d = tmo_cnt_q + 10'd1;
        else
            tmo_cnt_d = tmo_cnt_q;
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q     <= '1;
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            bit_idx_q  <= '0;
            data_q     <= '0;
            par_bit_q  <= 1'b0;
            fifo_en_q  <= 1'b0;
            overrun_q  <= 1'b0;
            tmo_cnt_q  <= '0;
        end else begin
            sync_q     <= sync_d;
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_idx_q  <= bit_idx_d;
            data_q     <= data_d;
            par_bit_q  <= par_bit_d;
            fifo_en_q  <= fifo_en_d;
            overrun_q  <= overrun_d;
            tmo_cnt_q  <= tmo_cnt_d;
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .fifo_en_i    (fifo_en_i),
        .flush_i      (flush),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop_i),
        .head_o       (head),
        .empty_o      (fifo_empty),
        .count_o      (rx_count_o),
        .pop_ok_o     (pop_ok),
        .overflow_o   (overflow),
        .err_any_o    (fifo_err_o)
    );

    // LSR view of the head entry plus interrupt-source outputs
    always_comb begin
        rdata_o        = head.data;
        parity_err_o   = head.pe;
        framing_err_o  = head.fe;
        break_o        = head.bi;
        data_ready_o   = !fifo_empty;
        overrun_o      = overrun_q;
        trig_reached_o = fifo_en_i && (rx_count_o >= trig_threshold(trig_level_i));
        timeout_o      = fifo_en_i &&
                         (tmo_cnt_q >= timeout_ticks(word_len_i, parity_en_i, stop_bits_i));
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: one task per scenario, inline checks.
module tb_uart_rx_core;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud_tick_i = 1'b0;
    logic       rx_i = 1'b1;
    logic [1:0] word_len_i = 2'd3;
    logic       stop_bits_i = 1'b0;
    logic       parity_en_i = 1'b0;
    logic       even_parity_i = 1'b0;
    logic       stick_parity_i = 1'b0;
    logic       fifo_en_i = 1'b0;
    logic       rx_fifo_reset_i = 1'b0;
    logic [1:0] trig_level_i = 2'd0;
    logic       pop_i = 1'b0;
    logic       lsr_clear_i = 1'b0;
    logic [7:0] rdata_o;
    logic       data_ready_o, overrun_o, parity_err_o, framing_err_o, break_o;
    logic       fifo_err_o, trig_reached_o, timeout_o;
    logic [4:0] rx_count_o;

    int total = 0;
    int bad   = 0;

    uart_rx_core #(
        .FIFO_DEPTH  (16),
        .SYNC_STAGES (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .baud_tick_i     (baud_tick_i),
        .rx_i            (rx_i),
        .word_len_i      (word_len_i),
        .stop_bits_i     (stop_bits_i),
        .parity_en_i     (parity_en_i),
        .even_parity_i   (even_parity_i),
        .stick_parity_i  (stick_parity_i),
        .fifo_en_i       (fifo_en_i),
        .rx_fifo_reset_i (rx_fifo_reset_i),
        .trig_level_i    (trig_level_i),
        .pop_i           (pop_i),
        .lsr_clear_i     (lsr_clear_i),
        .rdata_o         (rdata_o),
        .data_ready_o    (data_ready_o),
        .overrun_o       (overrun_o),
        .parity_err_o    (parity_err_o),
        .framing_err_o   (framing_err_o),
        .break_o         (break_o),
        .fifo_err_o      (fifo_err_o),
        .trig_reached_o  (trig_reached_o),
        .timeout_o       (timeout_o),
        .rx_count_o      (rx_count_o)
    );

    always #5 clk = ~clk;

    // 16x tick: one clock high out of every four, changed on falling edges
    initial begin
        forever begin
            repeat (3) @(negedge clk);
            baud_tick_i = 1'b1;
            @(negedge clk);
            baud_tick_i = 1'b0;
        end
    end

    // Returns just after the rising edge at which the n-th tick is sampled
    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (!baud_tick_i) @(posedge clk);
        end
        #1;
    endtask

    task automatic drive_bit(input logic b, input int n);
        rx_i = b;
        wait_ticks(n);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_bit, input int stop_ticks);
        wait_ticks(1);
        drive_bit(1'b0, 16);
        for (int i = 0; i < 5 + int'(word_len_i); i++) drive_bit(d[i], 16);
        if (parity_en_i) drive_bit(par_bit, 16);
        rx_i = 1'b1;
        if (stop_ticks > 0) wait_ticks(stop_ticks);
    endtask

    task automatic do_pop();
        @(negedge clk);
        pop_i = 1'b1;
        @(negedge clk);
        pop_i = 1'b0;
    endtask

    task automatic do_lsr_clear();
        @(negedge clk);
        lsr_clear_i = 1'b1;
        @(negedge clk);
        lsr_clear_i = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++; if (data_ready_o !== 1'b0) begin bad++; $display("FAIL reset_dr got=%b want=0", data_ready_o); end
        total++; if (rx_count_o !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", rx_count_o); end
        total++; if (rdata_o !== 8'h00) begin bad++; $display("FAIL reset_rdata got=%h want=00", rdata_o); end
        total++; if ({overrun_o, fifo_err_o, timeout_o, trig_reached_o} !== 4'b0000) begin
            bad++; $display("FAIL reset_flags got=%b want=0000", {overrun_o, fifo_err_o, timeout_o, trig_reached_o});
        end
        rst = 1'b0;
        fifo_en_i = 1'b1;
        repeat (4) @(negedge clk);
        $display("test_reset: done");
    endtask

    task automatic test_8n1();
        word_len_i = 2'd3; parity_en_i = 1'b0;
        send_frame(8'hA5, 1'b0, 16);
        total++; if (data_ready_o !== 1'b1) begin bad++; $display("FAIL 8n1_dr got=%b want=1", data_ready_o); end
        total++; if (rdata_o !== 8'hA5) begin bad++; $display("FAIL 8n1_rdata got=%h want=a5", rdata_o); end
        total++; if ({parity_err_o, framing_err_o, break_o} !== 3'b000) begin
            bad++; $display("FAIL 8n1_err got=%b want=000", {parity_err_o, framing_err_o, break_o});
        end
        do_pop();
        total++; if (data_ready_o !== 1'b0) begin bad++; $display("FAIL 8n1_pop_dr got=%b want=0", data_ready_o); end
        $display("test_8n1: rdata=%h", 8'hA5);
    endtask

    task automatic test_parity();
        word_len_i = 2'd2; parity_en_i = 1'b1; even_parity_i = 1'b1;
        // 0x41 has two set bits in 7 bits: even parity bit should be 0, send 1
        send_frame(8'h41, 1'b1, 16);
        total++; if (parity_err_o !== 1'b1) begin bad++; $display("FAIL par_pe got=%b want=1", parity_err_o); end
        total++; if (fifo_err_o !== 1'b1) begin bad++; $display("FAIL par_fifo_err got=%b want=1", fifo_err_o); end
        total++; if (rdata_o !== 8'h41) begin bad++; $display("FAIL par_rdata got=%h want=41", rdata_o); end
        total++; if (framing_err_o !== 1'b0) begin bad++; $display("FAIL par_fe got=%b want=0", framing_err_o); end
        do_pop();
        total++; if ({parity_err_o, fifo_err_o} !== 2'b00) begin
            bad++; $display("FAIL par_pop got=%b want=00", {parity_err_o, fifo_err_o});
        end
        // Correct parity bit: no error expected
        send_frame(8'h43, 1'b1, 16);
        total++; if ({parity_err_o, rdata_o} !== {1'b0, 8'h43}) begin
            bad++; $display("FAIL par_ok got=%b/%h want=0/43", parity_err_o, rdata_o);
        end
        do_pop();
        word_len_i = 2'd3; parity_en_i = 1'b0; even_parity_i = 1'b0;
        $display("test_parity: done");
    endtask

    task automatic test_false_start();
        wait_ticks(1);
        drive_bit(1'b0, 4);
        drive_bit(1'b1, 40);
        total++; if (rx_count_o !== 5'd0) begin bad++; $display("FAIL false_start_count got=%0d want=0", rx_count_o); end
        total++; if (data_ready_o !== 1'b0) begin bad++; $display("FAIL false_start_dr got=%b want=0", data_ready_o); end
        // The receiver must still decode a real frame afterwards
        send_frame(8'h5A, 1'b0, 16);
        total++; if (rdata_o !== 8'h5A) begin bad++; $display("FAIL false_start_next got=%h want=5a", rdata_o); end
        do_pop();
        $display("test_false_start: done");
    endtask

    task automatic test_break();
        wait_ticks(1);
        drive_bit(1'b0, 25 * 16);
        total++; if (rx_count_o !== 5'd1) begin bad++; $display("FAIL brk_count got=%0d want=1", rx_count_o); end
        total++; if (rdata_o !== 8'h00) begin bad++; $display("FAIL brk_rdata got=%h want=00", rdata_o); end
        total++; if ({break_o, framing_err_o, parity_err_o} !== 3'b110) begin
            bad++; $display("FAIL brk_flags got=%b want=110", {break_o, framing_err_o, parity_err_o});
        end
        total++; if (fifo_err_o !== 1'b1) begin bad++; $display("FAIL brk_fifo_err got=%b want=1", fifo_err_o); end
        drive_bit(1'b1, 16);
        send_frame(8'h3C, 1'b0, 16);
        total++; if (rx_count_o !== 5'd2) begin bad++; $display("FAIL brk_next_count got=%0d want=2", rx_count_o); end
        do_pop();
        total++; if ({rdata_o, break_o, fifo_err_o} !== {8'h3C, 1'b0, 1'b0}) begin
            bad++; $display("FAIL brk_next got=%h/%b/%b want=3c/0/0", rdata_o, break_o, fifo_err_o);
        end
        do_pop();
        $display("test_break: done");
    endtask

    task automatic test_holding();
        fifo_en_i = 1'b0;
        send_frame(8'h11, 1'b0, 16);
        send_frame(8'h22, 1'b0, 16);
        total++; if (rx_count_o !== 5'd1) begin bad++; $display("FAIL hold_count got=%0d want=1", rx_count_o); end
        total++; if (rdata_o !== 8'h11) begin bad++; $display("FAIL hold_rdata got=%h want=11", rdata_o); end
        total++; if (overrun_o !== 1'b1) begin bad++; $display("FAIL hold_ovr got=%b want=1", overrun_o); end
        total++; if (trig_reached_o !== 1'b0) begin bad++; $display("FAIL hold_trig got=%b want=0", trig_reached_o); end
        do_lsr_clear();
        do_pop();
        fifo_en_i = 1'b1;
        repeat (2) @(negedge clk);
        total++; if ({overrun_o, data_ready_o} !== 2'b00) begin
            bad++; $display("FAIL hold_after got=%b want=00", {overrun_o, data_ready_o});
        end
        $display("test_holding: done");
    endtask

    task automatic test_fifo_full();
        trig_level_i = 2'd3;
        for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b0, 16);
        total++; if (rx_count_o !== 5'd16) begin bad++; $display("FAIL full_count got=%0d want=16", rx_count_o); end
        total++; if (overrun_o !== 1'b1) begin bad++; $display("FAIL full_ovr got=%b want=1", overrun_o); end
        total++; if (rdata_o !== 8'h00) begin bad++; $display("FAIL full_rdata got=%h want=00", rdata_o); end
        total++; if (trig_reached_o !== 1'b1) begin bad++; $display("FAIL full_trig got=%b want=1", trig_reached_o); end
        do_lsr_clear();
        total++; if (overrun_o !== 1'b0) begin bad++; $display("FAIL full_ovr_clr got=%b want=0", overrun_o); end
        for (int i = 0; i < 16; i++) begin
            total++;
            if (rdata_o !== 8'(i)) begin bad++; $display("FAIL full_pop%0d got=%h want=%h", i, rdata_o, 8'(i)); end
            do_pop();
        end
        total++; if (data_ready_o !== 1'b0) begin bad++; $display("FAIL full_empty got=%b want=0", data_ready_o); end
        $display("test_fifo_full: done");
    endtask

    task automatic test_timeout();
        int k;
        int guard;
        trig_level_i = 2'd2;
        send_frame(8'h55, 1'b0, 16);
        send_frame(8'h66, 1'b0, 0);
        guard = 0;
        while (rx_count_o != 5'd2 && guard < 100) begin
            wait_ticks(1);
            guard++;
        end
        total++; if (rx_count_o !== 5'd2) begin bad++; $display("FAIL tmo_push got=%0d want=2", rx_count_o); end
        total++; if (trig_reached_o !== 1'b0) begin bad++; $display("FAIL tmo_trig got=%b want=0", trig_reached_o); end
        k = 0;
        while (timeout_o !== 1'b1 && k < 1000) begin
            wait_ticks(1);
            k++;
        end
        total++; if (k != 640) begin bad++; $display("FAIL tmo_ticks got=%0d want=640", k); end
        do_pop();
        total++; if (timeout_o !== 1'b0) begin bad++; $display("FAIL tmo_pop got=%b want=0", timeout_o); end
        do_pop();
        $display("test_timeout: rise after %0d ticks", k);
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_false_start();
        test_break();
        test_holding();
        test_fifo_full();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
Serial receive datapath of the 16550-style UART. It oversamples rx_i at 16x the baud rate and validates start bits. It deframes 5–8 data bits with optional parity and checks the stop bit. Received characters and their per-character error flags are buffered in an RX FIFO. The register/bus front end reads RBR/LSR data from this block and uses its trigger and timeout outputs for irq_o.

Parameters:
FIFO_DEPTH, 16, RX FIFO entries (power of 2).
SYNC_STAGES, 2, rx_i synchronizer flops (≥2).

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
baud_tick_i  in  1  one-clk pulse at 16x baud (from the baud generator)
rx_i  in  1  serial input, asynchronous, idle high
word_len_i  in  2  LCR[1:0]: 00=5 … 11=8 data bits
stop_bits_i  in  1  LCR[2]; used only for timeout frame length
parity_en_i  in  1  LCR[3]
even_parity_i  in  1  LCR[4]
stick_parity_i  in  1  LCR[5]
fifo_en_i  in  1  FCR[0]
rx_fifo_reset_i  in  1  FCR[1] write pulse
trig_level_i  in  2  FCR[7:6]: 1/4/8/14 characters
pop_i  in  1  RBR read pulse
lsr_clear_i  in  1  LSR read pulse
rdata_o  out  8  head character, show-ahead
data_ready_o  out  1  LSR[0], FIFO not empty
overrun_o  out  1  LSR[1], sticky
parity_err_o  out  1  LSR[2], head entry
framing_err_o  out  1  LSR[3], head entry
break_o  out  1  LSR[4], head entry
fifo_err_o  out  1  LSR[7], any stored entry has an error
trig_reached_o  out  1  FIFO level ≥ trigger
timeout_o  out  1  character timeout
rx_count_o  out  5  FIFO occupancy

Behaviour:
- Reset: all outputs 0; synchronizer flops 1; FSM IDLE; FIFO empty; all counters 0.
- The FSM advances only on baud_tick_i. A 4-bit tick counter is used.
- IDLE: when synchronized rx=0 on a tick → START, counter=0.
- START: at counter==7 (mid-bit), if rx=1 it is a false start → IDLE. Otherwise → DATA with counter=0.
- DATA: sample at each counter==15, LSB first. After 5+word_len_i bits → PARITY if parity_en_i is set, else STOP.
- PARITY: sample at counter==15. Expected parity bit:
  - stick_parity_i=1 → ~even_parity_i.
  - else even_parity_i=1 → ^data.
  - else ~^data.
  - Mismatch → pe=1.
- STOP: sample the first stop bit only; 0 → fe=1.
  - bi=1 if every data bit, the parity bit and the stop bit were 0.
  - Push {bi,fe,pe,data} in the same cycle. Data bits above the word length are 0.
  - Next state: BRK_WAIT if bi is set, else IDLE. Stop-bit rest time is not waited out, so back-to-back frames are accepted.
- BRK_WAIT: stay until synchronized rx=1, then → IDLE. Exactly one 0x00 entry is pushed per break.
- Capacity: FIFO_DEPTH when fifo_en_i=1, otherwise 1 (holding register).
- Full push: the new character is discarded, stored entries are unchanged, overrun_o=1.
- Push and pop in the same cycle while full: the pop takes effect first, so the push is accepted and there is no overrun.
- Pop while empty: ignored.
- Empty FIFO: rdata_o=0 and error outputs=0.
- overrun_o: cleared by lsr_clear_i; if set and clear occur in the same cycle, set wins.
- fifo_err_o: maintained by a counter of stored error entries, updated on push and pop.
- FIFO flush: rx_fifo_reset_i, or any change of fifo_en_i. A flush clears pointers, count, error counter and the timeout counter. It does not abort a frame in progress and does not clear overrun_o.
- Trigger: trig_reached_o = fifo_en_i && count ≥ {1,4,8,14}[trig_level_i].
- Timeout (FIFO mode only):
  - A 10-bit tick counter clears on push, pop, flush, or when the FIFO is empty; otherwise it increments per tick.
  - timeout_o=1 when count ≥ 4·16·F, where F = 1 + (5+wl) + parity_en + (stop_bits_i ? 2 : 1). Use 2 stop bits for the 1.5-stop-bit case too.
  - timeout_o stays high until the counter clears.
- The rx_count_o width is fixed at 5 bits.

Decomposition:
- uart_pkg:
  - uart_rx_state_e {IDLE, START, DATA, PARITY, STOP, BRK_WAIT}
  - uart_rx_entry_t {bi, fe, pe, data[7:0]}
  - TRIG_LVL constants 1/4/8/14
  - OVERSAMPLE=16
- Sub-module uart_rx_fifo: synchronous show-ahead FIFO of uart_rx_entry_t with flush, full/empty, count and error-entry counter.

Test Plan:
- 8N1, send 0xA5 → after the stop mid-bit tick: data_ready_o=1, rdata_o=0xA5, pe/fe/bi=0. pop_i → data_ready_o=0.
- 7E1, send 0x41 with parity bit 1 → parity_err_o=1, fifo_err_o=1, rdata_o=0x41. pop_i → both 0.
- rx_i low for 4 ticks, then high → FSM returns to IDLE and no push occurs (rx_count_o=0).
- 8N1, rx_i low for 25 bit times → exactly one entry: 0x00, bi=1, fe=1. Count stays 1 until rx_i goes high; the next frame then decodes normally.
- FIFO mode, 17 characters 0x00…0x10 with no pop → rx_count_o=16, overrun_o=1, rdata_o=0x00. lsr_clear_i → overrun_o=0. Popping all 16 returns 0x00…0x0F.
- 8N1, trigger=8, 2 characters → trig_reached_o=0. timeout_o rises 640 ticks after the second push. pop_i → timeout_o=0.
